// File: rtl/dot_channel_acc.sv
// Dot-product channel: LANES-wide signed MAC reduced over STEPS beats, then bias,
// optional ReLU and saturation. Four register stages: products, lane sum, accumulate, output.
module dot_channel_acc #(
    parameter int DATA_LEN = 16,
    parameter int LANES    = 36,
    parameter int STEPS    = 6,
    parameter int FRAC     = 8,
    parameter int ACC_LEN  = 48
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         flush,
    input  logic                         relu_en,
    input  logic signed [DATA_LEN-1:0]   bias,
    input  logic [LANES*DATA_LEN-1:0]    d,
    input  logic [LANES*DATA_LEN-1:0]    w,
    output logic                         busy,
    output logic                         out_valid,
    output logic signed [DATA_LEN-1:0]   q
);

    localparam int PROD_W = 2 * DATA_LEN;
    localparam int SUM_W  = PROD_W + $clog2(LANES);
    localparam int CNT_W  = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int EXT_W  = ACC_LEN + FRAC + 2;

    localparam logic signed [EXT_W-1:0] SAT_MAX =
        {{(EXT_W-DATA_LEN+1){1'b0}}, {(DATA_LEN-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] SAT_MIN =
        {{(EXT_W-DATA_LEN+1){1'b1}}, {(DATA_LEN-1){1'b0}}};

    // Handshake: no backpressure. A beat is taken on every edge with in_valid=1 and
    // flush=0; out_valid is a single-cycle pulse and q holds until the next pulse.

    // Beat counter
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, is_first, is_last;

    // Stage P
    logic signed [PROD_W-1:0]   prod_q [LANES];
    logic signed [PROD_W-1:0]   prod_d [LANES];
    logic                       p_valid_q, p_valid_d;
    logic                       p_first_q, p_first_d;
    logic                       p_last_q, p_last_d;
    logic signed [DATA_LEN-1:0] p_bias_q, p_bias_d;
    logic                       p_relu_q, p_relu_d;

    // Stage S
    logic signed [SUM_W-1:0]    sum_q, sum_d;
    logic                       s_valid_q, s_valid_d;
    logic                       s_first_q, s_first_d;
    logic                       s_last_q, s_last_d;
    logic signed [DATA_LEN-1:0] s_bias_q, s_bias_d;
    logic                       s_relu_q, s_relu_d;

    // Stage A
    logic signed [ACC_LEN-1:0]  acc_q, acc_d;
    logic                       a_valid_q, a_valid_d;
    logic                       a_last_q, a_last_d;
    logic signed [DATA_LEN-1:0] a_bias_q, a_bias_d;
    logic                       a_relu_q, a_relu_d;

    // Stage O
    logic                       out_valid_q, out_valid_d;
    logic signed [DATA_LEN-1:0] q_q, q_d;

    logic signed [DATA_LEN-1:0] lane_d, lane_w;
    logic signed [EXT_W-1:0]    total, shifted, clipped;
    logic                       fire;

    always_comb begin
        accept   = in_valid & ~flush;
        is_first = (cnt_q == '0);
        is_last  = (cnt_q == CNT_W'(STEPS - 1));
        cnt_d    = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = is_last ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        lane_d    = '0;
        lane_w    = '0;
        p_valid_d = accept;
        p_first_d = is_first;
        p_last_d  = is_last;
        p_bias_d  = p_bias_q;
        p_relu_d  = p_relu_q;
        for (int i = 0; i < LANES; i++) begin
            lane_d    = d[i*DATA_LEN +: DATA_LEN];
            lane_w    = w[i*DATA_LEN +: DATA_LEN];
            prod_d[i] = PROD_W'(lane_d) * PROD_W'(lane_w);
        end
        // Bias and ReLU belong to the group, so they are latched only with its last beat.
        if (accept && is_last) begin
            p_bias_d = bias;
            p_relu_d = relu_en;
        end
    end

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < LANES; i++) begin
            sum_d = sum_d + SUM_W'(prod_q[i]);
        end
        s_valid_d = p_valid_q & ~flush;
        s_first_d = p_first_q;
        s_last_d  = p_last_q;
        s_bias_d  = p_bias_q;
        s_relu_d  = p_relu_q;
    end

    always_comb begin
        acc_d = acc_q;
        if (s_valid_q) begin
            acc_d = s_first_q ? ACC_LEN'(sum_q) : acc_q + ACC_LEN'(sum_q);
        end
        a_valid_d = s_valid_q & ~flush;
        a_last_d  = s_last_q;
        a_bias_d  = s_bias_q;
        a_relu_d  = s_relu_q;
    end

    // Bias is aligned to the accumulator's fixed point before the floor shift.
    always_comb begin
        total   = EXT_W'(acc_q) + (EXT_W'(a_bias_q) <<< FRAC);
        shifted = total >>> FRAC;
        clipped = shifted;
        if (a_relu_q && shifted[EXT_W-1]) begin
            clipped = '0;
        end else if (shifted > SAT_MAX) begin
            clipped = SAT_MAX;
        end else if (shifted < SAT_MIN) begin
            clipped = SAT_MIN;
        end
        fire        = a_valid_q & a_last_q & ~flush;
        out_valid_d = fire;
        q_d         = fire ? clipped[DATA_LEN-1:0] : q_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= '0;
            end
            p_valid_q   <= 1'b0;
            p_first_q   <= 1'b0;
            p_last_q    <= 1'b0;
            p_bias_q    <= '0;
            p_relu_q    <= 1'b0;
            sum_q       <= '0;
            s_valid_q   <= 1'b0;
            s_first_q   <= 1'b0;
            s_last_q    <= 1'b0;
            s_bias_q    <= '0;
            s_relu_q    <= 1'b0;
            acc_q       <= '0;
            a_valid_q   <= 1'b0;
            a_last_q    <= 1'b0;
            a_bias_q    <= '0;
            a_relu_q    <= 1'b0;
            out_valid_q <= 1'b0;
            q_q         <= '0;
        end else begin
            cnt_q       <= cnt_d;
            for (int i = 0; i < LANES; i++) begin
                prod_q[i] <= prod_d[i];
            end
            p_valid_q   <= p_valid_d;
            p_first_q   <= p_first_d;
            p_last_q    <= p_last_d;
            p_bias_q    <= p_bias_d;
            p_relu_q    <= p_relu_d;
            sum_q       <= sum_d;
            s_valid_q   <= s_valid_d;
            s_first_q   <= s_first_d;
            s_last_q    <= s_last_d;
            s_bias_q    <= s_bias_d;
            s_relu_q    <= s_relu_d;
            acc_q       <= acc_d;
            a_valid_q   <= a_valid_d;
            a_last_q    <= a_last_d;
            a_bias_q    <= a_bias_d;
            a_relu_q    <= a_relu_d;
            out_valid_q <= out_valid_d;
            q_q         <= q_d;
        end
    end

    assign busy      = (cnt_q != '0) | p_valid_q | s_valid_q | a_valid_q | out_valid_q;
    assign out_valid = out_valid_q;
    assign q         = q_q;

endmodule
